// File: rtl/wnd_ctl.sv
// -----------------------------------------------------------------------------
// wnd_ctl -- line buffer and timing generator feeding a COLS x ROWS window unit.
//
// Incoming dwords (four 8-bit pixels each) are queued in a line FIFO together
// with their in_last / in_eof markers. A line is only replayed once it sits
// complete in the FIFO. This guarantees a gap-free lv burst: one dword per
// cycle while lv is high. Each frame is framed by fv, with a fixed lead-in
// before the first line, at least GAP idle cycles after every line, and a
// tail before fv drops.
//
// Optional feature (compile-time macro WND_CTL_FLUSH_EN):
//   When defined, the eof line is followed by ROWS>>1 all-zero lines of the
//   same length. These flush the window unit's line memories. When the macro
//   is undefined there is no FLUSH state, and the eof line goes straight to
//   the tail.
//
// Parameters:
//   COLS  - window width in pixels; sets the inter-line gap (COLS>>2)+3
//   ROWS  - window height in rows; sets the number of flush lines
//   DEPTH - line FIFO depth in dwords, must be a power of two
//
// Ports:
//   c        in   clock
//   rst      in   synchronous active-high reset
//   in_d     in   [31:0] input dword
//   in_valid in   input dword valid
//   in_last  in   dword is the last one of its line
//   in_eof   in   line is the last one of the frame (qualified by in_last)
//   in_ready out  FIFO can accept a dword (not full)
//   p        out  [31:0] output dword, zero outside lv
//   lv       out  line valid
//   fv       out  frame valid
//   busy     out  controller is not idle
//   err_ovf  out  sticky: FIFO filled without holding a complete line
//   line_cnt out  [9:0] lines emitted in the current frame, saturating
// -----------------------------------------------------------------------------
module wnd_ctl #(
    parameter int COLS  = 7,
    parameter int ROWS  = 7,
    parameter int DEPTH = 512
) (
    input  logic        c,
    input  logic        rst,
    input  logic [31:0] in_d,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic        in_eof,
    output logic        in_ready,
    output logic [31:0] p,
    output logic        lv,
    output logic        fv,
    output logic        busy,
    output logic        err_ovf,
    output logic [9:0]  line_cnt
);

    localparam int GAP_CYC  = (COLS >> 2) + 3;
    localparam int LEAD_CYC = 4;
    localparam int AW       = $clog2(DEPTH);
    localparam int LW       = AW + 1;              // holds 0..DEPTH
    localparam int CW       = (LW > 16) ? LW : 16; // phase counter width

    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] LEAD_LAST = CW'(LEAD_CYC - 1);

    // Elaboration-time sanity check on the configuration.
    if (DEPTH != (1 << AW) || ROWS < 1 || COLS < 1) begin : g_cfg_check
        $error("wnd_ctl: DEPTH must be a power of two, ROWS and COLS positive");
    end

`ifdef WND_CTL_FLUSH_EN
    localparam logic [9:0] FLUSH_ROWS = 10'(ROWS >> 1);
    typedef enum logic [2:0] {IDLE, LEAD, LINE, GAP, FLUSH, TAIL} state_t;
`else
    typedef enum logic [2:0] {IDLE, LEAD, LINE, GAP, TAIL} state_t;
`endif

    // ---------------------------------------------------------------- FIFO
    logic [33:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [LW-1:0] lines_q;
    logic [33:0]   rd_word;
    logic          fifo_full;
    logic          push, pop, ovf;
    logic          rd_last, rd_eof;

    assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready  = ~fifo_full;
    assign push      = in_valid & in_ready;
    assign rd_word   = mem[rd_ptr[AW-1:0]];
    assign rd_last   = rd_word[32];
    assign rd_eof    = rd_word[33];
    // A full FIFO without one complete line can never drain: give up on it.
    assign ovf       = fifo_full && (lines_q == '0);

    // NOTE: the storage array has no reset; only the pointers decide which
    // entries are valid, so clearing them is enough and keeps this a plain RAM.
    always_ff @(posedge c) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {in_eof, in_last, in_d};
        end
    end

    // NOTE: every sequential block uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge c) begin
        if (rst || ovf) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            lines_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            // A line arriving and a line leaving in one cycle cancel out.
            case ({push && in_last, pop && rd_last})
                2'b10:   lines_q <= lines_q + 1'b1;
                2'b01:   lines_q <= lines_q - 1'b1;
                default: ;
            endcase
        end
    end

    // ----------------------------------------------------------------- FSM
    state_t        state, state_nxt;
    logic [CW-1:0] cnt;       // cycles spent in the current phase
    logic          cnt_clr;
    logic          lv_nxt;
    logic          line_end;  // an emitted line finishes this cycle
    logic          line_eof;  // the most recent line closed the frame

`ifdef WND_CTL_FLUSH_EN
    logic          flush_gap;  // FLUSH: idle gap after a zero line
    logic [9:0]    flush_rows; // zero lines emitted so far
    logic [LW-1:0] line_len;   // dwords popped so far in this line
    logic [LW-1:0] last_len;   // length of the most recent line
`endif

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        pop       = 1'b0;
        lv_nxt    = 1'b0;
        line_end  = 1'b0;

        case (state)
            IDLE: begin
                if (lines_q != '0) state_nxt = LEAD;
            end
            LEAD: begin
                if (cnt == LEAD_LAST) state_nxt = LINE;
            end
            LINE: begin
                // The whole line is already buffered, so popping never stalls.
                pop    = 1'b1;
                lv_nxt = 1'b1;
                if (rd_last) begin
                    line_end  = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (cnt >= GAP_LAST) begin
                    if (line_eof) begin
`ifdef WND_CTL_FLUSH_EN
                        state_nxt = (FLUSH_ROWS != '0) ? FLUSH : TAIL;
`else
                        state_nxt = TAIL;
`endif
                    end else if (lines_q != '0) begin
                        state_nxt = LINE;
                    end
                end
            end
`ifdef WND_CTL_FLUSH_EN
            FLUSH: begin
                if (!flush_gap) begin
                    lv_nxt = 1'b1;
                    if (cnt[LW-1:0] == last_len - 1'b1) begin
                        line_end = 1'b1;
                        cnt_clr  = 1'b1;
                    end
                end else if (cnt == GAP_LAST) begin
                    if (flush_rows == FLUSH_ROWS) state_nxt = TAIL;
                    else                          cnt_clr   = 1'b1;
                end
            end
`endif
            TAIL: begin
                if (cnt == GAP_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (ovf) begin
            state_nxt = IDLE;
            pop       = 1'b0;
            lv_nxt    = 1'b0;
            line_end  = 1'b0;
        end
        if (state_nxt != state) cnt_clr = 1'b1;
    end

    always_ff @(posedge c) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            line_eof <= 1'b0;
            err_ovf  <= 1'b0;
            line_cnt <= '0;
            fv       <= 1'b0;
            lv       <= 1'b0;
            p        <= '0;
        end else begin
            state <= state_nxt;

            if (cnt_clr)         cnt <= '0;
            else if (cnt != '1)  cnt <= cnt + 1'b1;

            if (pop && rd_last) line_eof <= rd_eof;

            if (ovf) err_ovf <= 1'b1;

            if (state_nxt == IDLE)                 line_cnt <= '0;
            else if (line_end && line_cnt != '1)   line_cnt <= line_cnt + 1'b1;

            // Outputs trail the state by one cycle, matching the pop -> p latency.
            fv <= (state != IDLE) && !ovf;
            lv <= lv_nxt;
            p  <= pop ? rd_word[31:0] : '0;
        end
    end

`ifdef WND_CTL_FLUSH_EN
    always_ff @(posedge c) begin
        if (rst) begin
            flush_gap  <= 1'b0;
            flush_rows <= '0;
            line_len   <= '0;
            last_len   <= '0;
        end else begin
            if (pop) begin
                if (rd_last) begin
                    last_len <= line_len + 1'b1;
                    line_len <= '0;
                end else begin
                    line_len <= line_len + 1'b1;
                end
            end

            if (state != FLUSH) begin
                flush_gap  <= 1'b0;
                flush_rows <= '0;
            end else if (line_end) begin
                flush_gap  <= 1'b1;
                flush_rows <= flush_rows + 1'b1;
            end else if (flush_gap && cnt_clr) begin
                flush_gap  <= 1'b0;
            end
        end
    end
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_wnd_ctl.sv
// -----------------------------------------------------------------------------
// tb_wnd_ctl -- directed self-checking bench for wnd_ctl (default parameters:
// COLS=7 -> gap 4, ROWS=7, DEPTH=512). Output activity is recorded each cycle
// and every frame is compared against the dwords the bench itself sent.
// -----------------------------------------------------------------------------
module tb_wnd_ctl;

    logic        c = 1'b0;
    logic        rst;
    logic [31:0] in_d;
    logic        in_valid, in_last, in_eof;
    logic        in_ready;
    logic [31:0] p;
    logic        lv, fv, busy, err_ovf;
    logic [9:0]  line_cnt;

    int n_cmp = 0;
    int n_err = 0;

    bit          rec = 1'b0;
    bit          tr_fv[$];
    bit          tr_lv[$];
    logic [31:0] tr_p[$];
    int          tr_lc[$];

    int          exp_len[$];
    logic [31:0] exp_dat[$];
    int          exp_lc;

    wnd_ctl dut (
        .c        (c),
        .rst      (rst),
        .in_d     (in_d),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_eof   (in_eof),
        .in_ready (in_ready),
        .p        (p),
        .lv       (lv),
        .fv       (fv),
        .busy     (busy),
        .err_ovf  (err_ovf),
        .line_cnt (line_cnt)
    );

    always #5 c = ~c;

    always @(negedge c) begin
        if (rec) begin
            tr_fv.push_back(fv);
            tr_lv.push_back(lv);
            tr_p.push_back(p);
            tr_lc.push_back(int'(line_cnt));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the dword was taken.
    task automatic push(input logic [31:0] d, input logic last, input logic eof);
        int t = 0;
        in_d = d; in_last = last; in_eof = eof; in_valid = 1'b1;
        while (!in_ready && t < 1000) begin
            @(negedge c);
            t++;
        end
        check("push_accept", t < 1000, 1);
        @(negedge c);
        in_valid = 1'b0; in_last = 1'b0; in_eof = 1'b0;
    endtask

    task automatic send_line(input logic [31:0] base, input int n, input bit eof, input bit toggle);
        for (int j = 0; j < n; j++) begin
            push(base + 32'(j), j == n - 1, eof && (j == n - 1));
            exp_dat.push_back(base + 32'(j));
            if (toggle) @(negedge c);
        end
        exp_len.push_back(n);
    endtask

    task automatic expect_zero_lines(input int rows, input int n);
        for (int r = 0; r < rows; r++) begin
            for (int j = 0; j < n; j++) exp_dat.push_back(32'd0);
            exp_len.push_back(n);
        end
    endtask

    task automatic start_frame();
        tr_fv.delete(); tr_lv.delete(); tr_p.delete(); tr_lc.delete();
        exp_len.delete(); exp_dat.delete();
        rec = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        repeat (4) @(negedge c);
        while ((busy || fv) && t < 5000) begin
            @(negedge c);
            t++;
        end
        check(tag, t < 5000, 1);
        repeat (2) @(negedge c);
        rec = 1'b0;
    endtask

    // Walk the recorded trace: lead-in, each line's run and data, gaps, tail.
    task automatic check_frame(input string tag, input bit exact_gap);
        int n = tr_fv.size();
        int i = 0;
        int k = 0;
        int run;
        int lc_max = 0;
        for (int j = 0; j < n; j++) if (tr_lc[j] > lc_max) lc_max = tr_lc[j];
        while (i < n && !tr_fv[i]) i++;
        check($sformatf("%s_fv_rise", tag), i < n, 1);
        run = 0;
        while (i < n && tr_fv[i] && !tr_lv[i]) begin run++; i++; end
        check($sformatf("%s_lead", tag), run, 4);
        for (int l = 0; l < exp_len.size(); l++) begin
            run = 0;
            while (i < n && tr_lv[i]) begin
                if (k < exp_dat.size())
                    check($sformatf("%s_p_l%0d_d%0d", tag, l, run), tr_p[i], exp_dat[k]);
                run++; k++; i++;
            end
            check($sformatf("%s_len_l%0d", tag, l), run, exp_len[l]);
            run = 0;
            while (i < n && tr_fv[i] && !tr_lv[i]) begin run++; i++; end
            if (l == exp_len.size() - 1)
                check($sformatf("%s_gap_tail", tag), run, 8);
            else if (exact_gap)
                check($sformatf("%s_gap_l%0d", tag, l), run, 4);
            else
                check($sformatf("%s_gapmin_l%0d", tag, l), run >= 4, 1);
        end
        check($sformatf("%s_fv_fall", tag), (i < n) ? tr_fv[i] : 1'b1, 0);
        check($sformatf("%s_dwords", tag), k, exp_dat.size());
        check($sformatf("%s_line_cnt_max", tag), lc_max, exp_lc);
        check($sformatf("%s_line_cnt_idle", tag), line_cnt, 0);
    endtask

    initial begin
        int t;
        rst = 1'b1;
        in_d = '0; in_valid = 1'b0; in_last = 1'b0; in_eof = 1'b0;
        repeat (3) @(negedge c);
        rst = 1'b0;
        @(negedge c);

        // Reset state.
        check("rst_fv", fv, 0);
        check("rst_lv", lv, 0);
        check("rst_p", p, 0);
        check("rst_busy", busy, 0);
        check("rst_err_ovf", err_ovf, 0);
        check("rst_line_cnt", line_cnt, 0);
        check("rst_in_ready", in_ready, 1);

        // Frame A: two lines of 4 dwords, back-to-back input.
        start_frame();
        send_line(32'h1100_0000, 4, 1'b0, 1'b0);
        send_line(32'h1200_0000, 4, 1'b1, 1'b0);
        exp_lc = 2;
        wait_idle("a_idle");
        check_frame("a", 1'b1);

        // Frame B: in_valid toggling every other cycle, three lines.
        start_frame();
        send_line(32'h2100_0000, 4, 1'b0, 1'b1);
        send_line(32'h2200_0000, 4, 1'b0, 1'b1);
        send_line(32'h2300_0000, 4, 1'b1, 1'b1);
        exp_lc = 3;
        wait_idle("b_idle");
        check_frame("b", 1'b0);

        // Frame C: eof line of 6 dwords (flush lines follow when enabled).
        start_frame();
        send_line(32'h3100_0000, 4, 1'b0, 1'b0);
        send_line(32'h3200_0000, 6, 1'b1, 1'b0);
`ifdef WND_CTL_FLUSH_EN
        expect_zero_lines(3, 6);
        exp_lc = 5;
`else
        exp_lc = 2;
`endif
        wait_idle("c_idle");
        check_frame("c", 1'b1);

        // Overflow: 513 cycles of valid data without in_last.
        in_last = 1'b0; in_eof = 1'b0; in_valid = 1'b1;
        for (int j = 0; j < 513; j++) begin
            in_d = 32'hA000_0000 + 32'(j);
            @(negedge c);
        end
        in_valid = 1'b0;
        check("ovf_err", err_ovf, 1);
        check("ovf_fv", fv, 0);
        check("ovf_lv", lv, 0);
        check("ovf_busy", busy, 0);
        check("ovf_in_ready", in_ready, 1);
        @(negedge c);

        // Frame D: normal frame after overflow; err_ovf stays set.
        start_frame();
        send_line(32'h4100_0000, 4, 1'b0, 1'b0);
        send_line(32'h4200_0000, 4, 1'b1, 1'b0);
        exp_lc = 2;
        wait_idle("d_idle");
        check_frame("d", 1'b1);
        check("d_err_sticky", err_ovf, 1);

        // Frame E: reset while the second dword of the first line is on p.
        send_line(32'h5100_0000, 4, 1'b0, 1'b0);
        send_line(32'h5200_0000, 4, 1'b1, 1'b0);
        t = 0;
        while (!(lv === 1'b1 && p === 32'h5100_0001) && t < 500) begin
            @(negedge c);
            t++;
        end
        check("e_reach_dword2", t < 500, 1);
        rst = 1'b1;
        @(negedge c);
        check("e_rst_lv", lv, 0);
        check("e_rst_fv", fv, 0);
        check("e_rst_p", p, 0);
        check("e_rst_busy", busy, 0);
        check("e_rst_err_ovf", err_ovf, 0);
        check("e_rst_line_cnt", line_cnt, 0);
        rst = 1'b0;
        @(negedge c);
        check("e_rel_in_ready", in_ready, 1);
        check("e_rel_busy", busy, 0);

        // Frame F: fresh frame after the mid-line reset starts at its first dword.
        start_frame();
        send_line(32'h6100_0000, 4, 1'b0, 1'b0);
        send_line(32'h6200_0000, 4, 1'b1, 1'b0);
        exp_lc = 2;
        wait_idle("f_idle");
        check_frame("f", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
